uart_tx_fifo: RTL and testbench

//  Transmit byte buffer between the UART register interface and the uart_tx serializer.
//  Bus writes push bytes; a small FSM pops one byte at a time and hands it to the serializer.
//  The FSM waits for the serializer's done pulse before starting the next byte.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 90 +++++++++
 rtl/uart_tx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//  Shared definitions for the UART block: transmit FSM state encoding,
//  register map offsets and default buffer geometry.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Default FIFO geometry. DEPTH must be a power of two and at least 2.
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 8;

  // Register map byte offsets.
  localparam logic [3:0] ADDR_CTRL = 4'd0;
  localparam logic [3:0] ADDR_TX   = 4'd4;
  localparam logic [3:0] ADDR_RX   = 4'd8;
  localparam logic [3:0] ADDR_STAT = 4'd12;

  // Transmit hand-off FSM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//  Single-clock circular buffer with an explicit occupancy counter. Shared by
//  the TX and RX paths of the UART.
//
//  Ports
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset (pointers and level)
//   clr_i    in   synchronous flush; overrides push and pop in the same cycle
//   push_i   in   push request; ignored while full
//   pop_i    in   pop request; ignored while empty
//   wdata_i  in   push data
//   rdata_o  out  head entry (valid whenever empty_o is low)
//   full_o   out  level == DEPTH
//   empty_o  out  level == 0
//   level_o  out  occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q,  level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full/empty are the pre-edge values, so a push at full is dropped even
  // when a pop happens in the same cycle.
  assign push_ok = push_i && !full_o  && !clr_i;
  assign pop_ok  = pop_i  && !empty_o && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers are AW bits wide, so DEPTH-1 -> 0 wrap is implicit.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
      else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset so it can map onto distributed or block RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//  Transmit byte buffer between the register interface and the serializer.
//  Bus writes push bytes; a three-state FSM pops one byte, pulses tx_start_o
//  and waits for tx_done_i before it may pop the next one.
//
//  Ports
//   clk_i      in   clock
//   rst_i      in   asynchronous active-high reset
//   en_i       in   transmit enable; only gates the start of a new byte
//   clr_i      in   synchronous flush of contents and overflow flag
//   wr_i       in   push strobe
//   wdata_i    in   push data
//   wm_i       in   low-watermark threshold
//   tx_done_i  in   serializer done pulse (only observed while waiting)
//   tx_start_o out  one-cycle start pulse to the serializer
//   tx_byte_o  out  byte under transmission, held from start until done
//   busy_o     out  FSM not idle
//   full_o     out  FIFO full
//   empty_o    out  FIFO empty
//   level_o    out  occupancy 0..DEPTH
//   ovf_o      out  sticky: a push was dropped because the FIFO was full
//   intr_wm_o  out  en_i && level_o <= wm_i
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW:0]      wm_i,
  input  logic             tx_done_i,
  output logic             tx_start_o,
  output logic [WIDTH-1:0] tx_byte_o,
  output logic             busy_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o,
  output logic             ovf_o,
  output logic             intr_wm_o
);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] tx_byte_q, tx_byte_d;
  logic             ovf_q, ovf_d;
  logic             pop_req;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_level;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .push_i  (wr_i),
    .pop_i   (pop_req),
    .wdata_i (wdata_i),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Hand-off FSM. A flush never aborts a byte already handed to the
  // serializer, but it does block a pop in the same cycle.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    pop_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && !fifo_empty && !clr_i) begin
          pop_req   = 1'b1;
          tx_byte_d = fifo_head;
          state_d   = START;
        end
      end
      START:   state_d = WAIT;
      WAIT:    if (tx_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Overflow: flush wins over a same-cycle push, so no drop is recorded then.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_i)                  ovf_d = 1'b0;
    else if (wr_i && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tx_byte_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx_start_o = (state_q == START);
  assign busy_o     = (state_q != IDLE);
  assign tx_byte_o  = tx_byte_q;
  assign full_o     = fifo_full;
  assign empty_o    = fifo_empty;
  assign level_o    = fifo_level;
  assign ovf_o      = ovf_q;
  assign intr_wm_o  = en_i && (fifo_level <= wm_i);

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//  Queue-based reference model plus a byte scoreboard for uart_tx_fifo.
//  Inputs change 1 ns after the rising edge; outputs are checked on the
//  falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic             clr_i;
  logic             wr_i;
  logic [WIDTH-1:0] wdata_i;
  logic [AW:0]      wm_i;
  logic             tx_done_i;
  logic             tx_start_o;
  logic [WIDTH-1:0] tx_byte_o;
  logic             busy_o;
  logic             full_o;
  logic             empty_o;
  logic [AW:0]      level_o;
  logic             ovf_o;
  logic             intr_wm_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .wr_i       (wr_i),
    .wdata_i    (wdata_i),
    .wm_i       (wm_i),
    .tx_done_i  (tx_done_i),
    .tx_start_o (tx_start_o),
    .tx_byte_o  (tx_byte_o),
    .busy_o     (busy_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .level_o    (level_o),
    .ovf_o      (ovf_o),
    .intr_wm_o  (intr_wm_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // m_q holds the bytes waiting in the buffer; m_phase: 0 idle, 1 start, 2 wait.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_phase = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;
  int         m_n;

  initial begin
    forever begin
      @(posedge clk or posedge rst_i);
      if (rst_i) begin
        m_q.delete();
        exp_q.delete();
        m_phase = 0;
        m_byte  = 8'h00;
        m_ovf   = 1'b0;
      end else begin
        m_n = m_q.size();
        if (m_phase == 0) begin
          if (en_i && m_n > 0 && !clr_i) begin
            m_byte = m_q.pop_front();
            exp_q.push_back(m_byte);
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else if (tx_done_i) begin
          m_phase = 0;
        end
        if (clr_i) begin
          m_q.delete();
          m_ovf = 1'b0;
        end else if (wr_i) begin
          if (m_n == DEPTH) m_ovf = 1'b1;
          else m_q.push_back(wdata_i);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] sb_exp;
  initial begin
    forever begin
      @(negedge clk);
      chk("level", 32'(level_o), 32'(m_q.size()));
      chk("full", 32'(full_o), 32'(m_q.size() == DEPTH));
      chk("empty", 32'(empty_o), 32'(m_q.size() == 0));
      chk("ovf", 32'(ovf_o), 32'(m_ovf));
      chk("busy", 32'(busy_o), 32'(m_phase != 0));
      chk("tx_start", 32'(tx_start_o), 32'(m_phase == 1));
      chk("intr_wm", 32'(intr_wm_o), 32'(en_i && (m_q.size() <= int'(wm_i))));
      if (m_phase != 0) chk("tx_byte_hold", 32'(tx_byte_o), 32'(m_byte));
      if (tx_start_o) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_start", 32'(tx_byte_o), 32'hFFFF_FFFF);
        end else begin
          sb_exp = exp_q.pop_front();
          chk("sb_byte", 32'(tx_byte_o), 32'(sb_exp));
        end
      end
    end
  end

  // ---------------- serializer model (drives tx_done_i) ----------------
  int dly = 0;
  int stray_cnt = 0;
  int stray_done = 0;
  initial begin
    tx_done_i = 1'b0;
    forever begin
      tick();
      tx_done_i = 1'b0;
      if (rst_i) begin
        dly = 0;
      end else if (tx_start_o) begin
        dly = $urandom_range(2, 6);
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) tx_done_i = 1'b1;
      end else if (!busy_o && (stray_done < stray_cnt || $urandom_range(0, 15) == 0)) begin
        tx_done_i = 1'b1;
        if (stray_done < stray_cnt) stray_done++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_drained(input string name, input int max);
    int n = 0;
    while (!(empty_o && !busy_o) && n < max) begin
      tick();
      n++;
    end
    chk(name, 32'(n < max), 32'd1);
  endtask

  task automatic wait_in_wait(input string name, input int max);
    int n = 0;
    while (!(busy_o && !tx_start_o) && n < max) begin
      tick();
      n++;
    end
    chk(name, 32'(n < max), 32'd1);
  endtask

  task automatic push(input logic [7:0] d);
    wr_i = 1'b1;
    wdata_i = d;
    tick();
    wr_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int starts;
  int n;
  initial begin
    rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; wr_i = 1'b0; wdata_i = '0; wm_i = '0;
    repeat (3) tick();
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_byte", 32'(tx_byte_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // 1: single byte, start two cycles after the push
    en_i = 1'b1; wr_i = 1'b1; wdata_i = 8'hA5;
    tick();
    wr_i = 1'b0;
    chk("t1_level_after_push", 32'(level_o), 32'd1);
    chk("t1_no_start_yet", 32'(tx_start_o), 32'd0);
    tick();
    chk("t1_start", 32'(tx_start_o), 32'd1);
    chk("t1_byte", 32'(tx_byte_o), 32'hA5);
    chk("t1_level_after_pop", 32'(level_o), 32'd0);
    wait_drained("t1_drain_timeout", 50);

    // 2: fill to full, overflow, then drain in order
    en_i = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hFF);
    chk("t2_full", 32'(full_o), 32'd1);
    chk("t2_ovf", 32'(ovf_o), 32'd1);
    chk("t2_level", 32'(level_o), 32'd16);
    en_i = 1'b1;
    wait_drained("t2_drain_timeout", 400);
    chk("t2_ovf_sticky", 32'(ovf_o), 32'd1);
    clr_i = 1'b1; tick(); clr_i = 1'b0; tick();
    chk("t2_ovf_cleared", 32'(ovf_o), 32'd0);

    // 3: low watermark
    wm_i = 5'd2;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    chk("t3_level_above_wm", 32'(level_o > 2), 32'd1);
    chk("t3_intr_low", 32'(intr_wm_o), 32'd0);
    n = 0;
    while (level_o != 2 && n < 200) begin tick(); n++; end
    chk("t3_reach_wm_timeout", 32'(n < 200), 32'd1);
    chk("t3_intr_high", 32'(intr_wm_o), 32'd1);
    wait_drained("t3_drain_timeout", 200);

    // 4: drop enable mid-byte
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i));
    en_i = 1'b1;
    wait_in_wait("t4_wait_timeout", 20);
    en_i = 1'b0;
    starts = 0;
    repeat (30) begin tick(); if (tx_start_o) starts++; end
    chk("t4_no_start_disabled", 32'(starts), 32'd0);
    chk("t4_level_held", 32'(level_o), 32'd2);
    chk("t4_idle", 32'(busy_o), 32'd0);
    en_i = 1'b1;
    wait_drained("t4_drain_timeout", 100);

    // 5: flush during WAIT with a same-cycle push
    en_i = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    en_i = 1'b1;
    n = 0;
    while (!tx_start_o && n < 20) begin tick(); n++; end
    chk("t5_start_timeout", 32'(n < 20), 32'd1);
    tick();
    chk("t5_level3", 32'(level_o), 32'd3);
    clr_i = 1'b1; wr_i = 1'b1; wdata_i = 8'h99;
    tick();
    clr_i = 1'b0; wr_i = 1'b0;
    chk("t5_level0", 32'(level_o), 32'd0);
    chk("t5_ovf0", 32'(ovf_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd1);
    chk("t5_byte_held", 32'(tx_byte_o), 32'h60);
    starts = 0;
    repeat (15) begin tick(); if (tx_start_o) starts++; end
    chk("t5_no_new_start", 32'(starts), 32'd0);
    chk("t5_idle", 32'(busy_o), 32'd0);

    // 6: asynchronous reset during WAIT
    push(8'h11); push(8'h22);
    wait_in_wait("t6_wait_timeout", 20);
    @(posedge clk); #2;
    rst_i = 1'b1;
    #1;
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_start", 32'(tx_start_o), 32'd0);
    chk("t6_level", 32'(level_o), 32'd0);
    chk("t6_empty", 32'(empty_o), 32'd1);
    chk("t6_byte", 32'(tx_byte_o), 32'd0);
    tick();
    rst_i = 1'b0;
    stray_cnt++;
    starts = 0;
    repeat (10) begin tick(); if (tx_start_o) starts++; end
    chk("t6_stray_done_ignored", 32'(starts), 32'd0);
    chk("t6_still_idle", 32'(busy_o), 32'd0);

    // Randomized traffic
    for (int seg = 0; seg < 6; seg++) begin
      int wr_pct = $urandom_range(20, 90);
      wm_i = 5'($urandom_range(0, 16));
      repeat (500) begin
        wr_i    = ($urandom_range(0, 99) < wr_pct);
        wdata_i = 8'($urandom);
        clr_i   = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 39) == 0) en_i = ~en_i;
        tick();
      end
    end
    wr_i = 1'b0; clr_i = 1'b0; en_i = 1'b1;
    wait_drained("final_drain_timeout", 500);
    repeat (3) tick();
    chk("sb_all_consumed", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_fifo
